seg7_scan_controller: RTL and testbench

SEG7_SCAN_CONTROLLER -- requirements
Module: seg7_scan_controller

---
 rtl/seg7_scan_controller.sv | 184 ++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_controller.sv
// Multiplexed seven-segment scan controller: double-buffered digit data, leading-zero
// blanking, per-slot PWM brightness and registered anode/cathode drive.
module seg7_scan_controller #(
  parameter int unsigned NUM_DIGITS      = 8,
  parameter int unsigned TICKS_PER_DIGIT = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  input  logic                    lz_suppress,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode,
  output logic                    frame_start
);

  localparam int unsigned SubCnt = TICKS_PER_DIGIT / 16;
  localparam int unsigned SubW   = (SubCnt > 1) ? $clog2(SubCnt) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [SubW-1:0] SubMax = SubW'(SubCnt - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic                    lz;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [4*NUM_DIGITS-1:0] digits;
  } disp_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan counters
  logic [SubW-1:0] sub_q, sub_d;
  logic [3:0]      phase_q, phase_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            sub_wrap, phase_wrap, frame_end;

  always_comb begin
    sub_wrap   = (sub_q == SubMax);
    phase_wrap = sub_wrap && (phase_q == 4'hF);
    frame_end  = phase_wrap && (idx_q == IdxMax);
    sub_d      = sub_wrap ? '0 : sub_q + 1'b1;
    phase_d    = sub_wrap ? phase_q + 4'h1 : phase_q;
    idx_d      = idx_q;
    if (phase_wrap) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      sub_q   <= sub_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  // Pending/shadow buffers; shadow only changes at the frame boundary
  disp_t in_frame;
  disp_t pend_q, pend_d;
  disp_t shd_q, shd_d;
  logic  pend_flag_q, pend_flag_d;

  always_comb begin
    in_frame    = {lz_suppress, blank, dp, digits};
    pend_d      = pend_q;
    shd_d       = shd_q;
    pend_flag_d = pend_flag_q;
    if (load) begin
      pend_d      = in_frame;
      pend_flag_d = 1'b1;
    end
    if (frame_end) begin
      if (load) begin
        shd_d       = in_frame;
        pend_flag_d = 1'b0;
      end else if (pend_flag_q) begin
        shd_d       = pend_q;
        pend_flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      shd_q       <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      shd_q       <= shd_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  // Digit i is a leading zero when it and every digit above it are zero
  logic [NUM_DIGITS-1:0] suppress;
  logic                  zero_run;

  always_comb begin
    zero_run = 1'b1;
    suppress = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run    = zero_run && (shd_q.digits[4*i +: 4] == 4'h0);
      suppress[i] = shd_q.lz && (i != 0) && zero_run;
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dp, cur_blank, cur_sup, cur_lit;

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_sup   = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_nib   = shd_q.digits[4*i +: 4];
        cur_dp    = shd_q.dp[i];
        cur_blank = shd_q.blank[i];
        cur_sup   = suppress[i];
      end
    end
    // A suppressed digit still lights when its dp is set
    cur_lit = !cur_blank && (!cur_sup || cur_dp) && (phase_q <= brightness);
  end

  logic [NUM_DIGITS-1:0] anode_d;
  logic [7:0]            cathode_d;
  logic                  frame_start_d;

  always_comb begin
    anode_d       = '1;
    cathode_d     = 8'hFF;
    frame_start_d = (idx_q == '0) && (phase_q == 4'h0) && (sub_q == '0);
    if (cur_lit) begin
      anode_d   = ~(NUM_DIGITS'(1) << idx_q);
      cathode_d = {~cur_dp, cur_sup ? 7'h7F : seg_decode(cur_nib)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode       <= '1;
      cathode     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      anode       <= anode_d;
      cathode     <= cathode_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Scoreboard bench for seg7_scan_controller (4 digits, 32 ticks per slot): stimulus queues
// the expected frame, a monitor checks every cycle of the frame that follows frame_start.
module tb_seg7_scan_controller;

  localparam int unsigned ND   = 4;
  localparam int unsigned TPD  = 32;
  localparam int          SLOT = 32;
  localparam int          FRAME = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*ND-1:0] digits = '0;
  logic [ND-1:0] dp = '0;
  logic [ND-1:0] blank = '0;
  logic          load = 1'b0;
  logic          lz_suppress = 1'b0;
  logic [3:0]    brightness = 4'hF;
  logic [ND-1:0] anode;
  logic [7:0]    cathode;
  logic          frame_start;

  always #5 clk = ~clk;

  seg7_scan_controller #(
    .NUM_DIGITS      (ND),
    .TICKS_PER_DIGIT (TPD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits      (digits),
    .dp          (dp),
    .blank       (blank),
    .load        (load),
    .lz_suppress (lz_suppress),
    .brightness  (brightness),
    .anode       (anode),
    .cathode     (cathode),
    .frame_start (frame_start)
  );

  // Per-slot anode/cathode while lit (an == F means the slot stays dark) and lit cycles/slot
  typedef struct {
    logic [3:0][3:0] an;
    logic [3:0][7:0] ca;
    int              on;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t exp_rst;
  exp_t exp_t7;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_busy = 1'b0;

  function automatic exp_t mk(input logic [15:0] an, input logic [31:0] ca, input int on);
    exp_t e;
    e.an = an;
    e.ca = ca;
    e.on = on;
    return e;
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got {fs,an,ca}=%h, expected %h", name, act, req);
    end
  endtask

  // Monitor: checks the whole frame whenever an expectation is waiting at frame_start
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && frame_start && sb_q.size() > 0) begin
        mon_busy = 1'b1;
        mon_e = sb_q.pop_front();
        for (int c = 0; c < FRAME; c++) begin
          int          s;
          logic        lit;
          logic [12:0] req;
          if (c > 0) @(negedge clk);
          s   = c / SLOT;
          lit = (mon_e.an[s] != 4'hF) && ((c % SLOT) < mon_e.on);
          req = {(c == 0), lit ? mon_e.an[s] : 4'hF, lit ? mon_e.ca[s] : 8'hFF};
          check($sformatf("frame cycle %0d", c), {frame_start, anode, cathode}, req);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic lz);
    digits      = d;
    dp          = p;
    blank       = b;
    lz_suppress = lz;
    load        = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic wait_frame_start();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 400);
    check("frame_start wait", 13'(frame_start), 13'd1);
  endtask

  task automatic drain();
    int   k = 0;
    logic pending;
    while ((sb_q.size() > 0 || mon_busy) && k < 1000) begin
      @(posedge clk);
      k++;
    end
    pending = (sb_q.size() > 0) || mon_busy;
    check("scoreboard drain", 13'(pending), 13'd0);
    if (pending) sb_q.delete();
  endtask

  // Load mid-frame of an unchecked frame; the next frame must show the new data
  task automatic step(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                      input logic lz, input logic [3:0] br, input exp_t e);
    drain();
    wait_frame_start();
    repeat (5) @(posedge clk);
    #1 brightness = br;
    do_load(d, p, b, lz);
    sb_q.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_rst = mk(16'h7BDE, 32'hC0C0C0C0, 32);
    exp_t7  = mk(16'hFBFE, 32'hFF7FFFC0, 32);

    repeat (3) @(posedge clk);
    #1 check("reset state", {frame_start, anode, cathode}, {1'b0, 4'hF, 8'hFF});
    sb_q.push_back(exp_rst);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("first frame_start", {frame_start, anode, cathode}, {1'b1, 4'hE, 8'hC0});

    step(16'h1234, 4'h0, 4'h0, 1'b0, 4'hF, mk(16'h7BDE, 32'hF9A4B099, 32));
    step(16'hCDEF, 4'h0, 4'h0, 1'b0, 4'hF, mk(16'h7BDE, 32'hC6A1868E, 32));
    step(16'h0050, 4'h0, 4'h0, 1'b1, 4'hF, mk(16'hFFDE, 32'hFFFF92C0, 32));
    step(16'h0000, 4'h0, 4'h0, 1'b1, 4'hF, mk(16'hFFFE, 32'hFFFFFFC0, 32));
    step(16'h1234, 4'h0, 4'h0, 1'b0, 4'h3, mk(16'h7BDE, 32'hF9A4B099, 8));
    step(16'h1234, 4'h1, 4'h2, 1'b0, 4'hF, mk(16'h7BFE, 32'hF9A4FF19, 32));
    step(16'h0000, 4'h4, 4'h0, 1'b1, 4'hF, exp_t7);

    // Two loads in one frame: the frame keeps old data, only the second load appears next
    drain();
    wait_frame_start();
    repeat (5) @(posedge clk);
    sb_q.push_back(exp_t7);
    wait_frame_start();
    repeat (10) @(posedge clk);
    #1 do_load(16'hAAAA, 4'h0, 4'h0, 1'b0);
    repeat (50) @(posedge clk);
    #1 do_load(16'hBBBB, 4'h0, 4'h0, 1'b0);
    sb_q.push_back(mk(16'h7BDE, 32'h83838383, 32));

    // Load held high exactly in the boundary cycle (two cycles before the next frame_start)
    drain();
    wait_frame_start();
    repeat (FRAME - 2) @(posedge clk);
    #1 do_load(16'h5678, 4'h0, 4'h0, 1'b0);
    sb_q.push_back(mk(16'h7BDE, 32'h9282F880, 32));

    // Asynchronous reset mid-slot with a pending load that must be discarded
    drain();
    wait_frame_start();
    repeat (40) @(posedge clk);
    #1 do_load(16'h9999, 4'h0, 4'h0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("async reset", {frame_start, anode, cathode}, {1'b0, 4'hF, 8'hFF});
    repeat (2) @(posedge clk);
    #1 check("reset hold", {frame_start, anode, cathode}, {1'b0, 4'hF, 8'hFF});
    sb_q.push_back(exp_rst);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("frame_start after re-reset", {frame_start, anode, cathode},
             {1'b1, 4'hE, 8'hC0});
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
